// File: rtl/grant_scheduler_if.sv
// Handshake bundle between requesters and the grant scheduler.
// The scheduler uses the slave view; requesters use the master view.
interface grant_scheduler_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       preempt;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/grant_scheduler.sv
// Round-robin single-owner arbiter with bounded hold time.
// One idle cycle always separates consecutive grants.
module grant_scheduler #(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    grant_scheduler_if.slave bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic [2:0] last_q;
    logic [2:0] last_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       pre_q;
    logic       pre_d;
    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;

    localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);

    // Search upward from last+1; the previous owner is visited last.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = last_q;
        for (int i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            last_q  <= 3'd7;
            cnt_q   <= 5'd0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pre_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = GRANT;
                    idx_d   = winner;
                    cnt_d   = 5'd1;
                end
            end
            GRANT: begin
                // Owner release wins over expiry on the same edge.
                if (!bus.req[idx_q]) begin
                    state_d = IDLE;
                    last_d  = idx_q;
                end else if (cnt_q == HOLD_MAX) begin
                    state_d = IDLE;
                    last_d  = idx_q;
                    pre_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.grant_valid = (state_q == GRANT);
    assign bus.grant       = (state_q == GRANT) ?
                             (8'b1 << idx_q) : 8'h00;
    assign bus.grant_idx   = idx_q;
    assign bus.preempt     = pre_q;

endmodule

// File: tb/tb_grant_scheduler.sv
// Randomized and directed checks of grant_scheduler
// against a cycle-level behavioural model.
module tb_grant_scheduler;

    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grant_scheduler_if bus ();

    grant_scheduler #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    int m_own;
    int m_held;
    int m_last;
    int m_idx;
    logic m_pre;

    logic [12:0] dut_vec;
    assign dut_vec = {bus.grant, bus.grant_idx,
                      bus.grant_valid, bus.preempt};

    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        g = 8'h00;
        if (m_own >= 0) g[m_own] = 1'b1;
        return {g, 3'(m_idx), (m_own >= 0), m_pre};
    endfunction

    task automatic model_reset();
        m_own  = -1;
        m_held = 0;
        m_last = 7;
        m_idx  = 0;
        m_pre  = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int c;
        if (m_own < 0) begin
            m_pre = 1'b0;
            for (int j = 1; j <= 8; j++) begin
                c = (m_last + j) % 8;
                if (r[c]) begin
                    m_own  = c;
                    m_idx  = c;
                    m_held = 1;
                    break;
                end
            end
        end else if (!r[m_own]) begin
            m_last = m_own;
            m_own  = -1;
            m_pre  = 1'b0;
        end else if (m_held == MH) begin
            m_last = m_own;
            m_own  = -1;
            m_pre  = 1'b1;
        end else begin
            m_held = m_held + 1;
            m_pre  = 1'b0;
        end
    endtask

    task automatic step(input logic [7:0] r);
        bus.req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        bus.req = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 8'hFF;
        model_reset();
        #3;
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h",
                     dut_vec, exp_vec());
        end
        @(posedge clk);
        #1;
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h",
                     dut_vec, exp_vec());
        end
        rst = 1'b0;
        step(8'h0F);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_first_prio: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_first_grant();
        apply_reset();
        step(8'b0000_0100);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant !== 8'h04) begin
            fails++;
            $display("FAIL first_grant: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_rotation();
        int owners[$];
        int exp_own[9];
        int npre;
        logic prev_v;
        exp_own = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        npre    = 0;
        prev_v  = 1'b0;
        apply_reset();
        for (int i = 0; i < 41; i++) begin
            step(8'hFF);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL rotation_cycle%0d: got %h expected %h",
                         i, dut_vec, exp_vec());
            end
            if (bus.grant_valid && !prev_v) owners.push_back(int'(bus.grant_idx));
            if (bus.preempt) npre++;
            prev_v = bus.grant_valid;
        end
        tests++;
        if (npre != 8) begin
            fails++;
            $display("FAIL rotation_preempts: got %0d expected 8", npre);
        end
        tests++;
        if (owners.size() != 9) begin
            fails++;
            $display("FAIL rotation_grants: got %0d expected 9",
                     owners.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                tests++;
                if (owners[k] != exp_own[k]) begin
                    fails++;
                    $display("FAIL rotation_owner%0d: got %0d expected %0d",
                             k, owners[k], exp_own[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(8'h04);
        step(8'h00);
        step(8'b0010_0101);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant_idx !== 3'd5) begin
            fails++;
            $display("FAIL wrap_idx5: got %h expected %h",
                     dut_vec, exp_vec());
        end
        step(8'b0000_0101);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant !== 8'h00) begin
            fails++;
            $display("FAIL wrap_idle: got %h expected %h",
                     dut_vec, exp_vec());
        end
        step(8'b0000_0101);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant !== 8'h01) begin
            fails++;
            $display("FAIL wrap_idx0: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_release();
        apply_reset();
        step(8'h08);
        step(8'h08);
        step(8'h00);
        tests++;
        if (dut_vec !== exp_vec() || bus.preempt !== 1'b0) begin
            fails++;
            $display("FAIL release_drop: got %h expected %h",
                     dut_vec, exp_vec());
        end
        step(8'h11);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant_idx !== 3'd4) begin
            fails++;
            $display("FAIL release_last3: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_same_edge();
        apply_reset();
        for (int i = 0; i < MH; i++) step(8'h02);
        step(8'h00);
        tests++;
        if (dut_vec !== exp_vec() || bus.preempt !== 1'b0) begin
            fails++;
            $display("FAIL same_edge_release: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < MH; i++) step(8'h02);
        step(8'h02);
        tests++;
        if (dut_vec !== exp_vec() || bus.preempt !== 1'b1) begin
            fails++;
            $display("FAIL b2b_preempt: got %h expected %h",
                     dut_vec, exp_vec());
        end
        step(8'h02);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant !== 8'h02) begin
            fails++;
            $display("FAIL b2b_regrant: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(8'h08);
        step(8'h08);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (dut_vec !== exp_vec() || dut_vec !== 13'h0) begin
            fails++;
            $display("FAIL async_reset_now: got %h expected %h",
                     dut_vec, exp_vec());
        end
        @(posedge clk);
        #1;
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL async_reset_held: got %h expected %h",
                     dut_vec, exp_vec());
        end
        rst = 1'b0;
        step(8'h80);
        tests++;
        if (dut_vec !== exp_vec() || bus.grant !== 8'h80) begin
            fails++;
            $display("FAIL async_reset_resume: got %h expected %h",
                     dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        apply_reset();
        r = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0) r = 8'($urandom);
            else if ($urandom_range(5) == 0) r[$urandom_range(7)] ^= 1'b1;
            if ($urandom_range(20) == 0) r = 8'h00;
            step(r);
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random_cycle%0d: req %h got %h expected %h",
                         i, r, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        bus.req = 8'h00;
        rst     = 1'b1;
        test_reset();
        test_first_grant();
        test_rotation();
        test_wrap();
        test_release();
        test_same_edge();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grant_scheduler.md
GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 SHALL provide parameter MAX_HOLD, default 16, meaning the maximum consecutive cycles one requester may hold a grant (legal range 1..31).
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, the reset: asynchronous, active-high.
REQ-004 SHALL provide port req, input, 8, per-requester request level; requester k holds req[k] high while it wants or owns the resource.
REQ-005 SHALL provide port grant, output logic, 8, one-hot grant: bit k high means requester k owns the resource; all-zero means no owner.
REQ-006 SHALL provide port grant_idx, output logic, 3, binary index of the current or most recent owner; grant equals the 3-to-8 one-hot decode of grant_idx whenever grant_valid=1.
REQ-007 SHALL provide port grant_valid, output logic, 1, high exactly when grant is non-zero.
REQ-008 SHALL provide port preempt, output logic, 1, a one-cycle pulse marking a forced release caused by MAX_HOLD expiry.

Function
REQ-009 SHALL implement two states: IDLE and GRANT.
REQ-010 SHALL keep grant=0 and grant_valid=0 in every IDLE cycle.
REQ-011 SHALL, in IDLE with req!=0 at a rising edge, select the winner as the first set req bit searching upward from (last+1) mod 8, wrapping 7->0.
REQ-012 SHALL, on that same edge, enter GRANT, drive grant=one-hot(winner), grant_idx=winner, grant_valid=1, and set hold_cnt=1; latency from req sampled to grant visible is therefore one edge.
REQ-013 SHALL, in IDLE with req==0, remain in IDLE and leave grant_idx and last unchanged.
REQ-014 SHALL, in GRANT when req[grant_idx]=0 at an edge, return to IDLE with grant=0 and last=grant_idx; preempt stays 0.
REQ-015 SHALL, in GRANT when req[grant_idx]=1 and hold_cnt==MAX_HOLD at an edge, return to IDLE with grant=0 and last=grant_idx, and pulse preempt=1 for exactly the following cycle.
REQ-016 SHALL, in GRANT when req[grant_idx]=1 and hold_cnt<MAX_HOLD, stay in GRANT and increment hold_cnt; a grant therefore lasts at most MAX_HOLD cycles.
REQ-017 SHALL ignore changes on non-owner req bits while in GRANT; they affect only the next IDLE selection.
REQ-018 SHALL insert exactly one IDLE cycle between any two consecutive grants, including the case where the same requester is re-granted.
REQ-019 SHALL, when only the previous owner is requesting at the IDLE evaluation edge, re-grant that owner, since the wrap search reaches it last.
REQ-020 SHALL, when the owner's req falls on the same edge that hold_cnt reaches MAX_HOLD, treat the event as a normal release with preempt=0.
REQ-021 SHALL size hold_cnt at 5 bits and never wrap it; it is reloaded only by REQ-012.

Reset
REQ-022 SHALL, while rst=1, force state=IDLE, grant=0, grant_idx=0, grant_valid=0, preempt=0, hold_cnt=0, and last=7 immediately, without waiting for a clock edge.
REQ-023 SHALL, with last=7 after reset, give requester 0 the highest priority for the first arbitration.
REQ-024 SHALL abort a grant in progress immediately on assertion of rst, with no preempt pulse, and SHALL resume arbitration at the first rising edge after rst falls.

Verification
REQ-025 Apply rst, then req=8'b00000100 -> one edge later grant=8'b00000100, grant_idx=2, grant_valid=1.
REQ-026 With MAX_HOLD=4, hold req=8'hFF -> owners cycle 0,1,2,...,7,0; each grant lasts 4 cycles followed by 1 idle cycle, and preempt pulses once per grant.
REQ-027 With last=2, apply req=8'b00100101 -> grant_idx=5; then drop req[5] -> the next grant goes to index 0 after one idle cycle.
REQ-028 While requester 3 owns the grant, drop req[3] at cycle 2 -> grant=0 after that edge, preempt=0, and last=3.
REQ-029 Assert rst asynchronously mid-grant, between clock edges -> grant, grant_valid and grant_idx read 0 immediately; after release, req=8'h80 -> grant=8'h80 one edge later.
REQ-030 With MAX_HOLD=4, drop the owner's req on its 4th held cycle -> release with preempt=0 (REQ-020).
